// File: rtl/bridge_mc.sv
// CPU-to-peripheral bridge with stride-decoded device windows and a built-in interrupt controller.
// Define BRIDGE_TIMEOUT_EN to abort device accesses that wait TIMEOUT cycles without an ack.
module bridge_mc #(
   parameter int unsigned NDEV    = 2,
   parameter logic [31:0] BASE    = 32'h0000_7F00,
   parameter logic [31:0] STRIDE  = 32'h10,
   parameter logic [31:0] WIN     = 32'h0C,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [31:0]          pr_addr,
   input  logic [31:0]          pr_wd,
   input  logic                 pr_we,
   input  logic                 pr_req,
   output logic [31:0]          pr_rd,
   output logic                 pr_ready,
   output logic                 pr_err,
   output logic [31:0]          dev_addr,
   output logic [31:0]          dev_wd,
   output logic [NDEV-1:0]      dev_sel,
   output logic [NDEV-1:0]      dev_we,
   input  logic [NDEV*32-1:0]   dev_rd,
   input  logic [NDEV-1:0]      dev_ack,
   input  logic [NDEV-1:0]      dev_int,
   output logic [5:0]           hw_int
);

   if (NDEV < 1 || NDEV > 6) begin : g_bad_ndev
      $error("bridge_mc: NDEV must be 1..6");
   end
   if (WIN > STRIDE) begin : g_bad_win
      $error("bridge_mc: WIN must not exceed STRIDE");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("bridge_mc: TIMEOUT must be 1..65535");
   end

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t          state;
   logic [2:0]      idx;
   logic            we;
`ifdef BRIDGE_TIMEOUT_EN
   logic [15:0]     cnt;
`endif

   logic [NDEV-1:0] mask;
   logic [NDEV-1:0] pending;
   logic [NDEV-1:0] prev;
   logic [NDEV-1:0] rise;
   logic            armed;

   logic            dev_hit;
   logic [2:0]      hit_idx;
   logic [31:0]     hit_off;
   logic [NDEV-1:0] hit_sel;
   logic [31:0]     icr_off;
   logic            icr_hit;
   logic [31:0]     icr_rd;
   logic [31:0]     sel_rd;
   logic            sel_ack;
   logic            accept;
   logic            wr_imr;
   logic            wr_ipr;

   // Unsigned wrap makes (addr - lo) < WIN a complete range test.
   always_comb begin
      dev_hit = 1'b0;
      hit_idx = '0;
      hit_off = '0;
      for (int unsigned i = 0; i < NDEV; i++) begin
         if (pr_addr - BASE - 32'(i) * STRIDE < WIN) begin
            dev_hit = 1'b1;
            hit_idx = 3'(i);
            hit_off = pr_addr - BASE - 32'(i) * STRIDE;
         end
      end
      hit_sel = NDEV'(1) << hit_idx;
   end

   always_comb begin
      icr_off = pr_addr - BASE - 32'(NDEV) * STRIDE;
      icr_hit = (icr_off == 32'h0) || (icr_off == 32'h4) || (icr_off == 32'h8);
      case (icr_off[3:0])
         4'h0:    icr_rd = 32'(mask);
         4'h4:    icr_rd = 32'(pending);
         default: icr_rd = 32'(dev_int);
      endcase
      sel_rd  = 32'(dev_rd >> {idx, 5'd0});
      sel_ack = |(dev_ack & (NDEV'(1) << idx));
      accept  = (state == IDLE) && pr_req;
      wr_imr  = accept && pr_we && !dev_hit && (icr_off == 32'h0);
      wr_ipr  = accept && pr_we && !dev_hit && (icr_off == 32'h4);
      rise    = armed ? (dev_int & ~prev) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         idx      <= '0;
         we       <= 1'b0;
         pr_rd    <= '0;
         pr_ready <= 1'b0;
         pr_err   <= 1'b0;
         dev_addr <= '0;
         dev_wd   <= '0;
         dev_sel  <= '0;
         dev_we   <= '0;
`ifdef BRIDGE_TIMEOUT_EN
         cnt      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               pr_ready <= 1'b0;
               if (pr_req) begin
                  if (dev_hit) begin
                     idx      <= hit_idx;
                     we       <= pr_we;
                     dev_addr <= hit_off;
                     dev_wd   <= pr_wd;
                     dev_sel  <= hit_sel;
                     dev_we   <= pr_we ? hit_sel : '0;
`ifdef BRIDGE_TIMEOUT_EN
                     cnt      <= '0;
`endif
                     state    <= ACCESS;
                  end else if (icr_hit) begin
                     pr_rd    <= pr_we ? '0 : icr_rd;
                     pr_err   <= 1'b0;
                     pr_ready <= 1'b1;
                     state    <= RESP;
                  end else begin
                     pr_rd    <= '0;
                     pr_err   <= 1'b1;
                     pr_ready <= 1'b1;
                     state    <= RESP;
                  end
               end
            end
            ACCESS: begin
               if (sel_ack) begin
                  pr_rd    <= we ? '0 : sel_rd;
                  pr_err   <= 1'b0;
                  dev_sel  <= '0;
                  dev_we   <= '0;
                  pr_ready <= 1'b1;
                  state    <= RESP;
               end
`ifdef BRIDGE_TIMEOUT_EN
               // Ack is tested first so it wins over a coincident timeout.
               else if (cnt == 16'(TIMEOUT)) begin
                  pr_rd    <= '0;
                  pr_err   <= 1'b1;
                  dev_sel  <= '0;
                  dev_we   <= '0;
                  pr_ready <= 1'b1;
                  state    <= RESP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
`endif
            end
            RESP: begin
               pr_ready <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // armed suppresses a false edge from a line already high when reset releases.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         mask    <= '1;
         prev    <= '0;
         armed   <= 1'b0;
         hw_int  <= '0;
      end else begin
         armed   <= 1'b1;
         prev    <= dev_int;
         pending <= (pending & ~(wr_ipr ? pr_wd[NDEV-1:0] : '0)) | rise;
         if (wr_imr)
            mask <= pr_wd[NDEV-1:0];
         hw_int  <= 6'(pending & mask);
      end
   end

endmodule

// File: tb/tb_bridge_mc.sv
// Scoreboard bench for bridge_mc (NDEV=2, BASE 0x7F00, STRIDE 0x10, WIN 0xC).
// Expected responses are queued at issue time and popped by a monitor on pr_ready.
module tb_bridge_mc;

   logic        clk;
   logic        reset_n;
   logic [31:0] pr_addr;
   logic [31:0] pr_wd;
   logic        pr_we;
   logic        pr_req;
   logic [31:0] pr_rd;
   logic        pr_ready;
   logic        pr_err;
   logic [31:0] dev_addr;
   logic [31:0] dev_wd;
   logic [1:0]  dev_sel;
   logic [1:0]  dev_we;
   logic [63:0] dev_rd;
   logic [1:0]  dev_ack;
   logic [1:0]  dev_int;
   logic [5:0]  hw_int;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } resp_t;
   resp_t exp_q[$];

   bridge_mc #(
      .NDEV(2), .BASE(32'h0000_7F00), .STRIDE(32'h10), .WIN(32'h0C), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_we(pr_we), .pr_req(pr_req),
      .pr_rd(pr_rd), .pr_ready(pr_ready), .pr_err(pr_err),
      .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_sel(dev_sel), .dev_we(dev_we),
      .dev_rd(dev_rd), .dev_ack(dev_ack), .dev_int(dev_int), .hw_int(hw_int)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && pr_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got pr_ready=1 expected no response at %0t", $time);
         end else begin
            resp_t r;
            r = exp_q.pop_front();
            chk("resp_rd", pr_rd, r.rd);
            chk("resp_err", 32'(pr_err), 32'(r.err));
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w);
      pr_addr = a;
      pr_wd   = d;
      pr_we   = w;
      pr_req  = 1'b1;
   endtask

   task automatic wait_ready(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pr_ready && n < budget);
   endtask

   // Single-cycle transaction (ICR access or miss): ready after one edge.
   task automatic simple(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [31:0] erd, input logic eerr);
      int n;
      exp_q.push_back('{rd: erd, err: eerr});
      issue(a, d, w);
      wait_ready(8, n);
      chk({name, "_latency"}, 32'(n), 32'd1);
      chk({name, "_no_sel"}, 32'(dev_sel), 32'd0);
      pr_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      reset_n = 1'b0;
      pr_addr = '0;
      pr_wd   = '0;
      pr_we   = 1'b0;
      pr_req  = 1'b0;
      dev_rd  = '0;
      dev_ack = '0;
      dev_int = 2'b01;
      repeat (3) @(negedge clk);
      chk("rst_pr_rd", pr_rd, 32'd0);
      chk("rst_pr_ready", 32'(pr_ready), 32'd0);
      chk("rst_pr_err", 32'(pr_err), 32'd0);
      chk("rst_dev_addr", dev_addr, 32'd0);
      chk("rst_dev_wd", dev_wd, 32'd0);
      chk("rst_dev_sel", 32'(dev_sel), 32'd0);
      chk("rst_dev_we", 32'(dev_we), 32'd0);
      chk("rst_hw_int", 32'(hw_int), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_edge_from_reset_hw", 32'(hw_int), 32'd0);
      simple("rst_ipr", 32'h7F24, 0, 1'b0, 32'h0, 1'b0);
      simple("rst_imr", 32'h7F20, 0, 1'b0, 32'h3, 1'b0);
      dev_int = 2'b00;
      repeat (2) @(negedge clk);

      // Device 1 read, immediate ack
      dev_rd = {32'hDEAD_BEEF, 32'h1111_2222};
      dev_ack = 2'b10;
      exp_q.push_back('{rd: 32'hDEAD_BEEF, err: 1'b0});
      issue(32'h7F14, 32'h0, 1'b0);
      @(negedge clk);
      chk("rd_dev_sel", 32'(dev_sel), 32'h2);
      chk("rd_dev_we", 32'(dev_we), 32'h0);
      chk("rd_dev_addr", dev_addr, 32'h4);
      wait_ready(8, n);
      chk("rd_latency", 32'(n + 1), 32'd2);
      chk("rd_sel_dropped", 32'(dev_sel), 32'h0);
      pr_req = 1'b0;
      dev_ack = 2'b00;
      @(negedge clk);

      // Device 0 write, ack after three wait cycles
      exp_q.push_back('{rd: 32'h0, err: 1'b0});
      issue(32'h7F08, 32'h1234, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk("wr_dev_we", 32'(dev_we), 32'h1);
         chk("wr_ready_low", 32'(pr_ready), 32'h0);
         if (c == 4) dev_ack = 2'b01;
      end
      chk("wr_dev_wd", dev_wd, 32'h1234);
      chk("wr_dev_addr", dev_addr, 32'h8);
      wait_ready(8, n);
      chk("wr_latency", 32'(n + 4), 32'd5);
      chk("wr_we_dropped", 32'(dev_we), 32'h0);
      pr_req = 1'b0;
      dev_ack = 2'b00;
      @(negedge clk);

      // Last byte of device 0; a non-selected device's ack must be ignored
      dev_rd = {32'hFFFF_FFFF, 32'hA5A5_0001};
      dev_ack = 2'b10;
      exp_q.push_back('{rd: 32'hA5A5_0001, err: 1'b0});
      issue(32'h7F0B, 32'h0, 1'b0);
      @(negedge clk);
      chk("edge_dev_sel", 32'(dev_sel), 32'h1);
      chk("edge_dev_addr", dev_addr, 32'hB);
      @(negedge clk);
      chk("foreign_ack_ignored", 32'(pr_ready), 32'h0);
      dev_ack = 2'b01;
      wait_ready(8, n);
      chk("edge_latency", 32'(n + 2), 32'd3);
      pr_req = 1'b0;
      dev_ack = 2'b00;
      @(negedge clk);

      // Misses
      simple("miss_gap0", 32'h7F0C, 0, 1'b0, 32'h0, 1'b1);
      simple("miss_gap1", 32'h7F1C, 0, 1'b0, 32'h0, 1'b1);
      simple("miss_below", 32'h7EFF, 0, 1'b0, 32'h0, 1'b1);
      simple("miss_icr_c", 32'h7F2C, 0, 1'b0, 32'h0, 1'b1);

      // Interrupt path
      dev_int = 2'b10;
      @(negedge clk);
      chk("int_hw_early", 32'(hw_int), 32'h0);
      @(negedge clk);
      chk("int_hw_set", 32'(hw_int), 32'h2);
      simple("ipr_rd1", 32'h7F24, 0, 1'b0, 32'h2, 1'b0);
      simple("imr_wr0", 32'h7F20, 0, 1'b1, 32'h0, 1'b0);
      chk("int_hw_masked", 32'(hw_int), 32'h0);
      simple("ipr_rd2", 32'h7F24, 0, 1'b0, 32'h2, 1'b0);
      simple("imr_rd0", 32'h7F20, 0, 1'b0, 32'h0, 1'b0);
      simple("raw_rd", 32'h7F28, 0, 1'b0, 32'h2, 1'b0);
      dev_int = 2'b00;
      repeat (2) @(negedge clk);
      dev_int = 2'b10;
      simple("ipr_clr_vs_set", 32'h7F24, 32'h2, 1'b1, 32'h0, 1'b0);
      simple("ipr_rd3", 32'h7F24, 0, 1'b0, 32'h2, 1'b0);
      simple("ipr_clr", 32'h7F24, 32'h2, 1'b1, 32'h0, 1'b0);
      simple("ipr_rd4", 32'h7F24, 0, 1'b0, 32'h0, 1'b0);
      dev_int = 2'b11;
      repeat (2) @(negedge clk);
      chk("masked_hw", 32'(hw_int), 32'h0);
      simple("ipr_masked", 32'h7F24, 0, 1'b0, 32'h1, 1'b0);
      simple("imr_wr3", 32'h7F20, 32'h3, 1'b1, 32'h0, 1'b0);
      chk("unmasked_hw", 32'(hw_int), 32'h1);
      simple("imr_rd3", 32'h7F20, 0, 1'b0, 32'h3, 1'b0);

      // Reset during ACCESS: abandoned, no response
      issue(32'h7F10, 32'h55, 1'b1);
      repeat (3) @(negedge clk);
      chk("abort_dev_we", 32'(dev_we), 32'h2);
      reset_n = 1'b0;
      #1;
      chk("abort_dev_sel", 32'(dev_sel), 32'h0);
      chk("abort_dev_we0", 32'(dev_we), 32'h0);
      chk("abort_dev_wd", dev_wd, 32'h0);
      chk("abort_hw_int", 32'(hw_int), 32'h0);
      pr_req = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_no_ready", 32'(pr_ready), 32'h0);
      chk("abort_no_edge_hw", 32'(hw_int), 32'h0);

`ifdef BRIDGE_TIMEOUT_EN
      exp_q.push_back('{rd: 32'h0, err: 1'b1});
      issue(32'h7F00, 32'h0, 1'b0);
      wait_ready(40, n);
      chk("timeout_latency", 32'(n), 32'd18);
      chk("timeout_sel_dropped", 32'(dev_sel), 32'h0);
      pr_req = 1'b0;
      @(negedge clk);
`endif

      repeat (2) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bridge_mc.md
# bridge_mc

Parametrised multi-device system bridge between the CPU data port and up to six memory-mapped peripherals (timers and successors). Decodes a contiguous, stride-spaced window per device, runs a registered request/acknowledge transaction to the selected device, and returns read data with a ready/error handshake. It also owns a built-in interrupt controller with per-device edge-latched pending bits and a mask register, and drives the CPU `hw_int[15:10]` lines.

## Interface
- `NDEV`, 2: number of devices, 1..6.
- `BASE`, 32'h0000_7F00: byte address of device 0's window.
- `STRIDE`, 32'h10: byte spacing between device windows.
- `WIN`, 32'h0C: window size in bytes, WIN ≤ STRIDE.
- `TIMEOUT`, 16: ACCESS-state cycle limit. Used only with `BRIDGE_TIMEOUT_EN`.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pr_addr`  in  32  CPU byte address.
- `pr_wd`  in  32  CPU write data.
- `pr_we`  in  1  write when 1, read when 0. Sampled with `pr_req`.
- `pr_req`  in  1  access request. Held until `pr_ready`.
- `pr_rd`  out  32  read data. Registered. Valid while `pr_ready`=1.
- `pr_ready`  out  1  one-cycle transaction completion pulse.
- `pr_err`  out  1  bus error, qualified by `pr_ready`.
- `dev_addr`  out  32  latched `pr_addr` minus the device base.
- `dev_wd`  out  32  latched `pr_wd`.
- `dev_sel`  out  NDEV  one-hot device select.
- `dev_we`  out  NDEV  one-hot device write enable. Subset of `dev_sel`.
- `dev_rd`  in  NDEV*32  device read data. Device i occupies bits [32i+31:32i].
- `dev_ack`  in  NDEV  device completion. Sampled only for the selected device.
- `dev_int`  in  NDEV  device interrupt request lines, level.
- `hw_int`  out  6  registered interrupt vector; `hw_int[i]` = pending[i] & mask[i]. Bits ≥ NDEV are 0.

## Operation
- **Decode.** Device i is hit iff BASE+i·STRIDE ≤ `pr_addr` < BASE+i·STRIDE+WIN.
- **ICR window.** The interrupt control window is BASE+NDEV·STRIDE plus offset:
  - 0x0: IMR, read/write.
  - 0x4: IPR. Reads return pending bits; writing 1 to a bit clears it.
  - 0x8: RAW. Read-only view of `dev_int`.
  - Unused upper bits read as 0.
- **Misses.** Any other address is a miss.
- **FSM states.** IDLE, ACCESS, RESP.
- **IDLE.**
  - On `pr_req` that hits device i: latch index, `dev_addr`, `dev_wd` and `pr_we`; assert `dev_sel[i]` (and `dev_we[i]` if writing); go to ACCESS.
  - On `pr_req` that hits the ICR: perform the register read or write; load `pr_rd`; go to RESP.
  - On `pr_req` that misses: `pr_rd`=0, `pr_err`=1; go to RESP.
- **ACCESS.**
  - `dev_sel` and `dev_we` are held.
  - When `dev_ack[idx]`=1: capture that device's `dev_rd` slice into `pr_rd` (0 on writes); drop `dev_sel`/`dev_we`; go to RESP.
- **RESP.** `pr_ready`=1 for exactly one cycle; return to IDLE. A new request can be accepted on the next cycle.
- **Request changes mid-transaction.** `pr_req` or `pr_addr` changes after acceptance are ignored; the latched transaction completes.
- **Pending bits.**
  - pending[i] sets on a rising edge of `dev_int[i]`. The previous value is registered each cycle.
  - A set on the same edge as an IPR write-1-clear wins.
  - Masked bits still latch pending.

## Timing
- **Reset values.**
  - FSM=IDLE.
  - `pr_rd`, `pr_ready`, `pr_err`, `dev_addr`, `dev_wd`, `dev_sel`, `dev_we`, `hw_int` = 0.
  - pending=0, IMR=all ones (bits NDEV-1:0), previous-`dev_int`=0.
  - A `dev_int` already high out of reset does not produce an edge.
- **Device access.** Request sampled at edge 0. `dev_sel` is high after edge 0. If ack arrives in that cycle, `pr_ready` is high after edge 1. Minimum latency is 2 cycles; each ack wait cycle adds one.
- **ICR access or miss.** `pr_ready` is high after edge 0, i.e. one cycle of latency.
- **Interrupts.**
  - `dev_int` rise sampled at edge k: pending is set after k, and `hw_int` is high after k+1.
  - A mask write at edge k affects `hw_int` after k+1.
- **Reset mid-transaction.** Asynchronous; all outputs return to reset values immediately. The in-flight transaction is abandoned with no `pr_ready`.

## Configuration
- **`BRIDGE_TIMEOUT_EN` defined.**
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If the count reaches TIMEOUT without an ack: drop `dev_sel`/`dev_we`, `pr_rd`=0, `pr_err`=1; go to RESP.
  - If ack and the timeout occur in the same cycle, the ack wins.
- **`BRIDGE_TIMEOUT_EN` not defined.** No counter; ACCESS waits for the ack indefinitely.

## Test plan
- **Device read.** NDEV=2. Read 0x7F14 with device 1 acking immediately, dev_rd slice=0xDEADBEEF. Required: `dev_sel`=2'b10 and `dev_addr`=0x4 for one cycle; `pr_ready`=1 two cycles after the request, with `pr_rd`=0xDEADBEEF and `pr_err`=0.
- **Write with wait states.** Write 0x1234 to 0x7F08; device 0 acks after 3 cycles. Required: `dev_we`=2'b01 for 4 cycles, `dev_wd`=0x1234, `pr_ready` on the 5th cycle.
- **Miss.** Read 0x7F0C (the gap). Required: `pr_ready` after one cycle, `pr_err`=1, `pr_rd`=0, `dev_sel` never asserted.
- **Interrupt path.**
  - Raise `dev_int[1]`: `hw_int`=6'b000010 two cycles later.
  - Write IMR (0x7F20)=0: `hw_int`=0 while IPR still reads 0x2.
  - Write IPR (0x7F24)=0x2 on the same cycle as a new `dev_int[1]` rise: pending remains set.
- **Timeout.** With `BRIDGE_TIMEOUT_EN`, TIMEOUT=16, read device 0 with no ack. Required: `pr_err`=1 with `pr_ready` 17 cycles after acceptance. Separately, assert `reset_n`=0 during ACCESS: `dev_sel`=0 immediately, and no `pr_ready` pulse follows.
